// File: rtl/datastore_reader_pkg.sv
// Shared constants and state encoding for the datastore reader and writer.
package datastore_reader_pkg;

  localparam int NUM_BYTES = 28;
  localparam int BYTE_W    = 8;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/datastore_reader_if.sv
// Byte stream handshake between the datastore reader and its consumer.
interface datastore_reader_if #(
  parameter int BYTE_W = datastore_reader_pkg::BYTE_W,
  parameter int IDX_W  = datastore_reader_pkg::IDX_W
);

  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic [IDX_W-1:0]  index_out;

  modport master (
    output byte_out,
    output byte_valid,
    output index_out,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  index_out,
    output byte_ready
  );

endinterface

// File: rtl/datastore_byte_mux.sv
// Selects one byte out of the flat shadow store by index.
module datastore_byte_mux #(
  parameter int NUM_BYTES = datastore_reader_pkg::NUM_BYTES,
  parameter int BYTE_W    = datastore_reader_pkg::BYTE_W,
  parameter int IDX_W     = datastore_reader_pkg::IDX_W
) (
  input  logic [NUM_BYTES*BYTE_W-1:0] shadow,
  input  logic [IDX_W-1:0]            idx,
  output logic [BYTE_W-1:0]           byte_o
);

  // Out-of-range indices yield zero rather than X.
  always_comb begin
    byte_o = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == IDX_W'(i)) byte_o = shadow[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/datastore_reader.sv
// Snapshots the datastore on start and streams length bytes out over a valid/ready link.
module datastore_reader
  import datastore_reader_pkg::IDX_W;
  import datastore_reader_pkg::state_e;
  import datastore_reader_pkg::IDLE;
  import datastore_reader_pkg::SEND;
  import datastore_reader_pkg::DONE;
#(
  parameter int NUM_BYTES = datastore_reader_pkg::NUM_BYTES,
  parameter int BYTE_W    = datastore_reader_pkg::BYTE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BYTES*BYTE_W-1:0] datastore_in,
  input  logic [IDX_W-1:0]            length,
  input  logic                        start,
  datastore_reader_if.master          bus,
  output logic                        busy,
  output logic                        done
);

  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len);
    if (int'(len) > NUM_BYTES) return IDX_W'(NUM_BYTES);
    return len;
  endfunction

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            last_q, last_d;
  logic [NUM_BYTES*BYTE_W-1:0] shadow_q, shadow_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic [IDX_W-1:0]            eff_len;
  logic [BYTE_W-1:0]           mux_byte;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    eff_len  = clamp_len(length);
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = datastore_in;
          idx_d    = '0;
          last_d   = eff_len - IDX_W'(1);
          busy_d   = 1'b1;
          if (eff_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            state_d = SEND;
            valid_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.byte_ready) begin
          if (idx_q == last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Shadow and last-index registers carry data only and are left out of reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    last_q   <= last_d;
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  datastore_byte_mux #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W),
    .IDX_W     (IDX_W)
  ) u_mux (
    .shadow (shadow_q),
    .idx    (idx_q),
    .byte_o (mux_byte)
  );

  assign bus.byte_out   = valid_q ? mux_byte : '0;
  assign bus.byte_valid = valid_q;
  assign bus.index_out  = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
